// File: rtl/i2s_slave_xcvr.sv
// I2S slave transceiver: follows an external BCLK/LRCLK pair, deserialises left/right words and serialises D_L_I/D_R_I.
// Optional macro I2S_SLAVE_FRAME_ERR_EN adds the sticky FRAME_ERR_O slot-length check.
module i2s_slave_xcvr #(
  parameter int DATA_W      = 24,
  parameter int SLOT_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              BCLK_I,
  input  logic              LRCLK_I,
  input  logic              SDATA_I,
  output logic              SDATA_O,
  input  logic [DATA_W-1:0] D_L_I,
  input  logic [DATA_W-1:0] D_R_I,
  output logic              TX_LOAD_O,
  output logic [DATA_W-1:0] D_L_O,
  output logic [DATA_W-1:0] D_R_O,
  output logic              RX_VALID_O
`ifdef I2S_SLAVE_FRAME_ERR_EN
  ,
  output logic              FRAME_ERR_O
`endif
);

  localparam int CNT_W = $clog2(SLOT_W + 2);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(SLOT_W + 1);
  localparam logic [CNT_W-1:0]  CNT_DATA = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0] RX_MSB   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {WAIT_SYNC, LEFT, RIGHT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] bclk_sync, lrclk_sync, sdata_sync;
  logic bclk_s, lrclk_s, sdata_s;
  logic bclk_prev, rise_evt, fall_evt, lr_prev;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr, rx_mask, left_hold, right_hold;
  logic [DATA_W-1:0] tx_sr, tx_r;
  logic rx_pend;
  logic boundary, to_left, to_right, slot_bad;
  logic load_evt, latch_left, pair_done;

  assign bclk_s  = bclk_sync[SYNC_STAGES-1];
  assign lrclk_s = lrclk_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];

  // A slot boundary is an LRCLK change seen at a BCLK rise; that edge's data bit is the I2S delay bit.
  assign boundary = rise_evt && (lrclk_s != lr_prev);
  assign to_left  = boundary && !lrclk_s;
  assign to_right = boundary && lrclk_s;

`ifdef I2S_SLAVE_FRAME_ERR_EN
  assign slot_bad = (bit_cnt != CNT_W'(SLOT_W - 1));
`else
  assign slot_bad = 1'b0;
`endif

  always_ff @(posedge CLK_I) begin
    if (RST_I) state_q <= WAIT_SYNC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_evt   = 1'b0;
    latch_left = 1'b0;
    pair_done  = 1'b0;
    case (state_q)
      WAIT_SYNC: begin
        if (to_left) begin
          state_d  = LEFT;
          load_evt = 1'b1;
        end
      end
      LEFT: begin
        if (boundary) begin
          if (slot_bad) begin
            state_d = WAIT_SYNC;
          end else if (to_right) begin
            state_d    = RIGHT;
            latch_left = 1'b1;
          end
        end
      end
      RIGHT: begin
        if (boundary) begin
          if (slot_bad) begin
            state_d = WAIT_SYNC;
          end else if (to_left) begin
            state_d   = LEFT;
            pair_done = 1'b1;
            load_evt  = 1'b1;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      bclk_prev  <= 1'b0;
      rise_evt   <= 1'b0;
      fall_evt   <= 1'b0;
      lr_prev    <= 1'b0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      rx_mask    <= RX_MSB;
      left_hold  <= '0;
      right_hold <= '0;
      rx_pend    <= 1'b0;
      tx_sr      <= '0;
      tx_r       <= '0;
      SDATA_O    <= 1'b0;
      TX_LOAD_O  <= 1'b0;
      RX_VALID_O <= 1'b0;
      D_L_O      <= '0;
      D_R_O      <= '0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], BCLK_I};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], LRCLK_I};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], SDATA_I};
      bclk_prev  <= bclk_s;
      rise_evt   <= bclk_s & ~bclk_prev;
      fall_evt   <= ~bclk_s & bclk_prev;

      if (rise_evt) begin
        lr_prev <= lrclk_s;
        if (boundary) begin
          bit_cnt <= '0;
          rx_sr   <= '0;
          rx_mask <= RX_MSB;
        end else begin
          if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
          rx_mask <= rx_mask >> 1;
          // The mask walks MSB->LSB, so a short slot leaves its missing LSBs at zero.
          if (state_q != WAIT_SYNC && bit_cnt < CNT_DATA && sdata_s)
            rx_sr <= rx_sr | rx_mask;
        end
      end

      if (latch_left) left_hold  <= rx_sr;
      if (pair_done)  right_hold <= rx_sr;
      rx_pend    <= pair_done;
      RX_VALID_O <= rx_pend;
      if (rx_pend) begin
        D_L_O <= left_hold;
        D_R_O <= right_hold;
      end

      TX_LOAD_O <= load_evt;
      if (fall_evt) begin
        if (state_q == WAIT_SYNC) begin
          SDATA_O <= 1'b0;
        end else begin
          SDATA_O <= tx_sr[DATA_W-1];
          tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
        end
      end
      if (latch_left) tx_sr <= tx_r;
      // Words are taken at the end of the TX_LOAD_O cycle, while upstream holds them stable.
      if (TX_LOAD_O) begin
        tx_sr <= D_L_I;
        tx_r  <= D_R_I;
      end
    end
  end

`ifdef I2S_SLAVE_FRAME_ERR_EN
  always_ff @(posedge CLK_I) begin
    if (RST_I)
      FRAME_ERR_O <= 1'b0;
    else if (boundary && state_q != WAIT_SYNC && slot_bad)
      FRAME_ERR_O <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_i2s_slave_xcvr.sv
// Bench for i2s_slave_xcvr: an I2S master model drives BCLK/LRCLK/SDATA at CLK/32 and a frame-level model predicts outputs.
module tb_i2s_slave_xcvr;
  localparam int DATA_W      = 24;
  localparam int SLOT_W      = 32;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bclk = 1'b0;
  logic lrclk = 1'b0;
  logic sdata_in = 1'b0;
  logic [DATA_W-1:0] d_l_i = '0;
  logic [DATA_W-1:0] d_r_i = '0;
  logic sdata_out, tx_load, rx_valid;
  logic [DATA_W-1:0] d_l_o, d_r_o;
`ifdef I2S_SLAVE_FRAME_ERR_EN
  logic frame_err;
`endif

  i2s_slave_xcvr #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK_I(clk), .RST_I(rst), .BCLK_I(bclk), .LRCLK_I(lrclk), .SDATA_I(sdata_in),
    .SDATA_O(sdata_out), .D_L_I(d_l_i), .D_R_I(d_r_i), .TX_LOAD_O(tx_load),
    .D_L_O(d_l_o), .D_R_O(d_r_o), .RX_VALID_O(rx_valid)
`ifdef I2S_SLAVE_FRAME_ERR_EN
    , .FRAME_ERR_O(frame_err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // frame-level model state
  bit synced = 1'b0;
  bit last_lr = 1'b0;
  bit mon_en = 1'b0;
  logic [DATA_W-1:0] tx_l_mdl = '0, tx_r_mdl = '0;
  logic [DATA_W-1:0] cur_l = '0, cur_r = '0;
  logic [DATA_W-1:0] dec_l = '0, dec_r = '0;
  logic [DATA_W-1:0] exp_l_q[$];
  logic [DATA_W-1:0] exp_r_q[$];
  int rx_cyc_q[$];
  int load_cyc_q[$];
  int rx_seen = 0;
  int load_seen = 0;
  int mon_t;

  // scoreboard: every pulse must match the oldest predicted one
  always @(negedge clk) begin
    if (mon_en) begin
      if (rx_valid === 1'b1) begin
        rx_seen++;
        if (rx_cyc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rx_valid_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          mon_t = rx_cyc_q.pop_front();
          check("rx_latency", DATA_W'(cyc - mon_t), DATA_W'(SYNC_STAGES + 3));
          check("d_l_o", d_l_o, exp_l_q.pop_front());
          check("d_r_o", d_r_o, exp_r_q.pop_front());
        end
      end
      if (tx_load === 1'b1) begin
        load_seen++;
        checks++;
        if (load_cyc_q.size() == 0) begin
          errors++;
          $display("FAIL tx_load_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          mon_t = load_cyc_q.pop_front();
          if (cyc - mon_t < 1 || cyc - mon_t > 8) begin
            errors++;
            $display("FAIL tx_load_latency: got %0d cycles expected 1..8", cyc - mon_t);
          end
        end
      end
    end
  end

  // driver: one BCLK period of the master, bit j of the current slot
  task automatic bit_period(input bit ch, input logic [DATA_W-1:0] word, input int j,
                            input bit do_rst, input bit do_chg);
    logic [DATA_W-1:0] sh;
    logic exp_bit;
    sh = (j >= 1 && j <= DATA_W) ? (word >> (DATA_W - j)) : '0;
    bclk = 1'b0;
    lrclk = ch;
    sdata_in = sh[0];
    repeat (HALF) @(negedge clk);
    bclk = 1'b1;
    if (last_lr && !ch) begin
      load_cyc_q.push_back(cyc);
      if (synced) begin
        exp_l_q.push_back(cur_l);
        exp_r_q.push_back(cur_r);
        rx_cyc_q.push_back(cyc);
      end
      synced = 1'b1;
      tx_l_mdl = d_l_i;
      tx_r_mdl = d_r_i;
    end
    last_lr = ch;
    if (ch) cur_r = word;
    else    cur_l = word;
    sh = '0;
    if (synced && j >= 1 && j <= DATA_W) sh = (ch ? tx_r_mdl : tx_l_mdl) >> (DATA_W - j);
    exp_bit = sh[0];
    check("sdata_o", DATA_W'(sdata_out), DATA_W'(exp_bit));
    if (j >= 1 && j <= DATA_W) begin
      if (ch) dec_r = {dec_r[DATA_W-2:0], sdata_out};
      else    dec_l = {dec_l[DATA_W-2:0], sdata_out};
    end
    for (int k = 0; k < HALF; k++) begin
      @(negedge clk);
      if (do_rst && k == 2) rst = 1'b1;
      if (do_rst && k == 3) begin
        rst = 1'b0;
        check("rst_sdata_o", DATA_W'(sdata_out), '0);
        check("rst_tx_load", DATA_W'(tx_load), '0);
        check("rst_rx_valid", DATA_W'(rx_valid), '0);
        check("rst_d_l_o", d_l_o, '0);
        check("rst_d_r_o", d_r_o, '0);
        synced = 1'b0;
        last_lr = 1'b0;
      end
      if (do_chg && k == 4) begin
        d_l_i = DATA_W'($urandom);
        d_r_i = DATA_W'($urandom);
      end
    end
  endtask

  task automatic send_slot(input bit ch, input logic [DATA_W-1:0] word, input int first_j,
                           input int rst_j, input int chg_j);
    for (int j = first_j; j < SLOT_W; j++)
      bit_period(ch, word, j, j == rst_j, j == chg_j);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input int rst_j, input bit chg);
    send_slot(1'b0, l, 0, rst_j, -1);
    send_slot(1'b1, r, 0, -1, chg ? 10 : -1);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("reset_sdata_o", DATA_W'(sdata_out), '0);
    check("reset_tx_load", DATA_W'(tx_load), '0);
    check("reset_rx_valid", DATA_W'(rx_valid), '0);
    check("reset_d_l_o", d_l_o, '0);
    check("reset_d_r_o", d_r_o, '0);
    rst = 1'b0;
    mon_en = 1'b1;

    // join mid-way through a right slot, then three fixed frames
    d_l_i = 24'h800001;
    d_r_i = 24'h7FFFFE;
    send_slot(1'b1, 24'h000000, 20, -1, -1);
    check("no_pulse_before_sync", DATA_W'(rx_seen + load_seen), '0);
    for (int f = 0; f < 3; f++) send_frame(24'hA5A5A5, 24'h5A5A5A, -1, 1'b0);
    check("rx_pulse_count", DATA_W'(rx_seen), 24'd2);
    check("tx_load_count", DATA_W'(load_seen), 24'd3);
    check("lit_d_l_o", d_l_o, 24'hA5A5A5);
    check("lit_d_r_o", d_r_o, 24'h5A5A5A);
    check("lit_dec_l", dec_l, 24'h800001);
    check("lit_dec_r", dec_r, 24'h7FFFFE);

    // random traffic with the transmit words changing every frame
    for (int f = 0; f < 5; f++) send_frame(DATA_W'($urandom), DATA_W'($urandom), -1, 1'b1);

    // reset at bit 10 of a left slot, then resync and decode again
    send_frame(DATA_W'($urandom), DATA_W'($urandom), 10, 1'b1);
    send_frame(DATA_W'($urandom), DATA_W'($urandom), -1, 1'b1);
    send_frame(DATA_W'($urandom), DATA_W'($urandom), -1, 1'b0);
    for (int j = 0; j < 3; j++) bit_period(1'b0, 24'h000000, j, 1'b0, 1'b0);

    repeat (20) @(negedge clk);
    check("rx_pending", DATA_W'(rx_cyc_q.size()), '0);
    check("load_pending", DATA_W'(load_cyc_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
